// File: rtl/dual_issue_ctrl.sv
// rtl/dual_issue_ctrl.sv - in-order dual-issue controller with register scoreboard and halt drain
module dual_issue_ctrl #(
  parameter int MULDIV_LAT = 8,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       vld0,
  input  logic       vld1,
  input  logic [4:0] rs1_0,
  input  logic [4:0] rs2_0,
  input  logic [4:0] rd_0,
  input  logic       we_0,
  input  logic       ld_0,
  input  logic       st_0,
  input  logic       br_0,
  input  logic       md_0,
  input  logic       halt_0,
  input  logic [4:0] rs1_1,
  input  logic [4:0] rs2_1,
  input  logic [4:0] rd_1,
  input  logic       we_1,
  input  logic       ld_1,
  input  logic       st_1,
  input  logic       br_1,
  input  logic       md_1,
  input  logic       halt_1,
  input  logic       wb_vld_a,
  input  logic       wb_vld_b,
  input  logic [4:0] wb_rd_a,
  input  logic [4:0] wb_rd_b,
  output logic       issue0,
  output logic       issue1,
  output logic       stall,
  output logic       halted
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t           state, state_nxt;
  logic [31:0]      busy, busy_nxt;
  logic [CNT_W-1:0] md_cnt, md_cnt_nxt;

  logic [31:0] wb_mask, eff_busy, set_mask;
  logic        md_busy, ok0, ok1, pair_ok, md_issue, halt_issue;

  // Writebacks landing this cycle bypass the source check; busy[0] is never set,
  // so x0 always reads as ready.
  assign wb_mask  = (wb_vld_a ? (32'd1 << wb_rd_a) : 32'd0)
                  | (wb_vld_b ? (32'd1 << wb_rd_b) : 32'd0);
  assign eff_busy = busy & ~wb_mask;
  assign md_busy  = (md_cnt != '0);

  assign ok0 = vld0 & ~flush & ~eff_busy[rs1_0] & ~eff_busy[rs2_0]
             & ~(we_0 & busy[rd_0]) & ~(md_0 & md_busy);

  assign ok1 = vld1 & ~eff_busy[rs1_1] & ~eff_busy[rs2_1]
             & ~(we_1 & busy[rd_1]) & ~(md_1 & md_busy);

  assign pair_ok = ~halt_0 & ~br_0
                 & ~((ld_1 | st_1) & (ld_0 | st_0))
                 & ~(md_1 & md_0)
                 & ~(we_0 & (rd_0 != 5'd0)
                     & ((rd_0 == rs1_1) | (rd_0 == rs2_1) | (rd_0 == rd_1)));

  always_comb begin
    issue0 = 1'b0;
    issue1 = 1'b0;
    stall  = 1'b0;
    if (!rst) begin
      if (state == S_RUN) begin
        issue0 = ok0;
        issue1 = ok0 & ok1 & pair_ok;
      end
      stall = vld0 & ~issue0;
    end
  end

  assign halted = (state == S_HALTED) & ~rst;

  assign set_mask = ((issue0 & we_0 & (ld_0 | md_0) & (rd_0 != 5'd0)) ? (32'd1 << rd_0) : 32'd0)
                  | ((issue1 & we_1 & (ld_1 | md_1) & (rd_1 != 5'd0)) ? (32'd1 << rd_1) : 32'd0);
  assign busy_nxt = (busy & ~wb_mask) | set_mask;

  assign md_issue   = (issue0 & md_0) | (issue1 & md_1);
  assign halt_issue = (issue0 & halt_0) | (issue1 & halt_1);

  always_comb begin
    md_cnt_nxt = md_cnt;
    if (md_issue)
      md_cnt_nxt = CNT_W'(MULDIV_LAT);
    else if (md_busy)
      md_cnt_nxt = md_cnt - 1'b1;
  end

  // Drain completes on the edge where the last outstanding op retires.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:    if (halt_issue) state_nxt = S_DRAIN;
      S_DRAIN:  if ((busy_nxt == '0) && (md_cnt_nxt == '0)) state_nxt = S_HALTED;
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_RUN;
      busy   <= '0;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      busy   <= busy_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// tb/tb_dual_issue_ctrl.sv - directed scoreboard bench for dual_issue_ctrl
module tb_dual_issue_ctrl;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       we, ld, st, br, md, hlt;
  } slot_t;

  logic clk = 1'b0;
  logic rst, flush, vld0, vld1;
  slot_t s0, s1;
  logic wb_vld_a, wb_vld_b;
  logic [4:0] wb_rd_a, wb_rd_b;
  logic issue0, issue1, stall, halted;

  logic [3:0] exp_q[$];
  string      name_q[$];
  int vectors = 0;
  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dual_issue_ctrl #(.MULDIV_LAT(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .vld0(vld0), .vld1(vld1),
    .rs1_0(s0.rs1), .rs2_0(s0.rs2), .rd_0(s0.rd),
    .we_0(s0.we), .ld_0(s0.ld), .st_0(s0.st), .br_0(s0.br), .md_0(s0.md), .halt_0(s0.hlt),
    .rs1_1(s1.rs1), .rs2_1(s1.rs2), .rd_1(s1.rd),
    .we_1(s1.we), .ld_1(s1.ld), .st_1(s1.st), .br_1(s1.br), .md_1(s1.md), .halt_1(s1.hlt),
    .wb_vld_a(wb_vld_a), .wb_vld_b(wb_vld_b), .wb_rd_a(wb_rd_a), .wb_rd_b(wb_rd_b),
    .issue0(issue0), .issue1(issue1), .stall(stall), .halted(halted)
  );

  function automatic slot_t nop();
    return '0;
  endfunction
  function automatic slot_t alu(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    slot_t s = '0; s.rd = rd; s.rs1 = a; s.rs2 = b; s.we = 1'b1; return s;
  endfunction
  function automatic slot_t lw(input logic [4:0] rd, input logic [4:0] a);
    slot_t s = alu(rd, a, 5'd0); s.ld = 1'b1; return s;
  endfunction
  function automatic slot_t sw(input logic [4:0] a, input logic [4:0] b);
    slot_t s = '0; s.rs1 = a; s.rs2 = b; s.st = 1'b1; return s;
  endfunction
  function automatic slot_t mul(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    slot_t s = alu(rd, a, b); s.md = 1'b1; return s;
  endfunction
  function automatic slot_t beq(input logic [4:0] a, input logic [4:0] b);
    slot_t s = '0; s.rs1 = a; s.rs2 = b; s.br = 1'b1; return s;
  endfunction
  function automatic slot_t hlt();
    slot_t s = '0; s.hlt = 1'b1; return s;
  endfunction

  // exp = {issue0, issue1, stall, halted}
  task automatic step(input logic r, input logic f,
                      input logic v0, input slot_t i0, input logic v1, input slot_t i1,
                      input logic wa, input logic [4:0] ra, input logic wb, input logic [4:0] rb,
                      input logic [3:0] exp, input string nm);
    rst = r; flush = f; vld0 = v0; s0 = i0; vld1 = v1; s1 = i1;
    wb_vld_a = wa; wb_rd_a = ra; wb_vld_b = wb; wb_rd_b = rb;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    applied++;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [3:0] e, got;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      got = {issue0, issue1, stall, halted};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL %s: got {i0,i1,stall,halted}=%b expected %b", n, got, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; vld0 = 1'b0; vld1 = 1'b0; s0 = '0; s1 = '0;
    wb_vld_a = 1'b0; wb_vld_b = 1'b0; wb_rd_a = '0; wb_rd_b = '0;
    @(posedge clk); #1;
    step(1, 0, 1, alu(1, 0, 0), 1, alu(2, 0, 0), 0, 0, 0, 0, 4'b0000, "reset_outputs");

    step(0, 0, 1, alu(1, 0, 0), 1, alu(2, 0, 0), 0, 0, 0, 0, 4'b1100, "indep_pair");
    step(0, 0, 1, alu(5, 1, 2), 1, alu(6, 5, 3), 0, 0, 0, 0, 4'b1000, "raw_pair");
    step(0, 0, 1, alu(6, 5, 3), 0, nop(),        0, 0, 0, 0, 4'b1000, "raw_second");

    step(0, 0, 1, lw(7, 0),     0, nop(),        0, 0, 0, 0, 4'b1000, "lw_issue");
    step(0, 0, 1, alu(8, 7, 0), 0, nop(),        0, 0, 0, 0, 4'b0010, "load_use_stall1");
    step(0, 0, 1, alu(8, 7, 0), 0, nop(),        0, 0, 0, 0, 4'b0010, "load_use_stall2");
    step(0, 0, 1, alu(8, 7, 0), 0, nop(),        1, 7, 0, 0, 4'b1000, "load_use_bypass");

    step(0, 0, 1, mul(10, 1, 2), 1, mul(11, 1, 2), 0, 0, 0, 0, 4'b1000, "md_pair");
    for (int i = 0; i < 8; i++)
      step(0, 0, 1, mul(11, 1, 2), 0, nop(), 0, 0, 0, 0, 4'b0010, "md_busy_stall");
    step(0, 0, 1, mul(11, 1, 2), 0, nop(), 0, 0, 0, 0, 4'b1000, "md_reissue");
    step(0, 0, 0, nop(), 0, nop(), 1, 11, 1, 10, 4'b0000, "md_wb_idle");
    for (int i = 0; i < 8; i++)
      step(0, 0, 0, nop(), 0, nop(), 0, 0, 0, 0, 4'b0000, "idle");

    step(0, 0, 1, lw(3, 0),      1, sw(0, 4),       0, 0, 0, 0, 4'b1000, "mem_port");
    step(0, 0, 1, beq(0, 0),     1, alu(14, 0, 0),  1, 3, 0, 0, 4'b1000, "br_slot0");
    step(0, 0, 1, alu(15, 0, 0), 1, beq(0, 0),      0, 0, 0, 0, 4'b1100, "br_slot1");
    step(0, 1, 1, alu(16, 0, 0), 1, alu(17, 0, 0),  0, 0, 0, 0, 4'b0010, "flush");
    step(0, 0, 1, alu(16, 3, 0), 1, alu(17, 3, 0),  0, 0, 0, 0, 4'b1100, "wb_cleared_x3");

    step(0, 0, 1, lw(9, 0),      0, nop(),          0, 0, 0, 0, 4'b1000, "lw_x9");
    step(0, 0, 1, hlt(),         1, alu(18, 0, 0),  0, 0, 0, 0, 4'b1000, "halt_issue");
    step(0, 0, 1, alu(19, 0, 0), 0, nop(),          0, 0, 0, 0, 4'b0010, "drain_stall");
    step(0, 0, 1, alu(19, 0, 0), 0, nop(),          1, 9, 0, 0, 4'b0010, "drain_wb");
    step(0, 0, 1, alu(19, 0, 0), 0, nop(),          0, 0, 0, 0, 4'b0011, "halted_set");
    step(0, 0, 0, nop(),         0, nop(),          0, 0, 0, 0, 4'b0001, "halted_sticky");
    step(1, 0, 1, alu(19, 0, 0), 0, nop(),          0, 0, 0, 0, 4'b0000, "rst_during_halt");
    step(0, 0, 1, alu(1, 0, 0),  1, alu(2, 0, 0),   0, 0, 0, 0, 4'b1100, "resume_pair");
    step(0, 0, 1, lw(9, 0),      0, nop(),          0, 0, 0, 0, 4'b1000, "lw_x9_again");
    step(1, 0, 0, nop(),         0, nop(),          0, 0, 0, 0, 4'b0000, "rst_mid_op");
    step(0, 0, 1, alu(20, 9, 0), 0, nop(),          1, 9, 0, 0, 4'b1000, "busy_cleared_by_rst");

    @(negedge clk);
    @(negedge clk);
    if (vectors != applied) begin
      miscompares++;
      $display("FAIL vector count: checked %0d of %0d applied", vectors, applied);
    end
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %0d expectations left unchecked", exp_q.size());
    end
    if (miscompares != 0)
      $display("FAIL == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    else
      $display("PASS == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
